// File: rtl/stage_f_if.sv
// Fetch-stage signal bundle: instruction bus, decode hand-off and execute redirect.
// master = stage_f itself, slave = the surrounding bus/decode/execute environment.
interface stage_f_if;
  logic [63:0] i_adr_o;
  logic        i_cyc_o;
  logic        i_stb_o;
  logic        i_ack_i;
  logic [31:0] i_dat_i;
  logic        f_ack_o;
  logic [31:0] f_dat_o;
  logic [63:0] f_pc_o;
  logic        x_jmp_i;
  logic [63:0] x_pc_i;

  modport master (
    output i_adr_o, i_cyc_o, i_stb_o, f_ack_o, f_dat_o, f_pc_o,
    input  i_ack_i, i_dat_i, x_jmp_i, x_pc_i
  );

  modport slave (
    input  i_adr_o, i_cyc_o, i_stb_o, f_ack_o, f_dat_o, f_pc_o,
    output i_ack_i, i_dat_i, x_jmp_i, x_pc_i
  );
endinterface

// File: rtl/stage_f.sv
// Instruction fetch stage: owns the PC, runs Wishbone-classic reads and hands
// words to decode; redirects drop any stale word still in flight.
module stage_f #(
  parameter logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00
) (
  input  logic              clk_i,
  input  logic              reset_i,
  stage_f_if.master         bus,
  output logic [1:0]        dbg_state_o
);
  // Bus handshake: a read completes on the edge where cyc/stb and i_ack_i are
  // both high; the address is held unchanged from strobe to ack.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] tgt_q, tgt_d;
  logic        f_ack_q, f_ack_d;
  logic [31:0] f_dat_q, f_dat_d;
  logic [63:0] f_pc_q, f_pc_d;
  logic [63:0] jmp_pc;

  assign jmp_pc = {bus.x_pc_i[63:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      f_ack_q <= 1'b0;
      f_dat_q <= NOP;
      f_pc_q  <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      f_ack_q <= f_ack_d;
      f_dat_q <= f_dat_d;
      f_pc_q  <= f_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    f_ack_d = 1'b0;
    f_dat_d = f_dat_q;
    f_pc_d  = f_pc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (bus.x_jmp_i) pc_d = jmp_pc;
      end
      FETCH: begin
        if (bus.i_ack_i) begin
          if (bus.x_jmp_i) begin
            pc_d = jmp_pc;
          end else begin
            f_ack_d = 1'b1;
            f_dat_d = bus.i_dat_i;
            f_pc_d  = pc_q;
            pc_d    = pc_q + 64'd4;
          end
        end else if (bus.x_jmp_i) begin
          // Cannot retarget mid-cycle: park the target until the old read acks.
          tgt_d   = jmp_pc;
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (bus.i_ack_i) begin
          pc_d    = bus.x_jmp_i ? jmp_pc : tgt_q;
          state_d = FETCH;
        end else if (bus.x_jmp_i) begin
          tgt_d = jmp_pc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.i_adr_o = pc_q;
  assign bus.i_cyc_o = (state_q != IDLE);
  assign bus.i_stb_o = (state_q != IDLE);
  assign bus.f_ack_o = f_ack_q;
  assign bus.f_dat_o = f_dat_q;
  assign bus.f_pc_o  = f_pc_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_stage_f.sv
// Self-checking bench for stage_f: directed scenarios then random traffic,
// compared every cycle against a transaction-level fetch model.
module tb_stage_f;
  localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FF00;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  stage_f_if bus ();

  stage_f #(.RESET_PC(RPC)) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: is the bus running, which address is being read, and whether the
  // outstanding read is already known stale (with the place to go afterwards).
  logic        m_active;
  logic [63:0] m_adr;
  logic        m_stale;
  logic [63:0] m_next;
  logic        m_fack;
  logic [31:0] m_fdat;
  logic [63:0] m_fpc;
  logic [95:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_adr    = RPC;
    m_stale  = 1'b0;
    m_next   = RPC;
    m_fack   = 1'b0;
    m_fdat   = 32'h0000_0013;
    m_fpc    = RPC;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic [95:0] e;
    chk("cyc", {63'd0, bus.i_cyc_o}, {63'd0, m_active});
    chk("stb", {63'd0, bus.i_stb_o}, {63'd0, m_active});
    chk("adr", bus.i_adr_o, m_adr);
    chk("f_ack", {63'd0, bus.f_ack_o}, {63'd0, m_fack});
    chk("f_dat", {32'd0, bus.f_dat_o}, {32'd0, m_fdat});
    chk("f_pc", bus.f_pc_o, m_fpc);
    if (bus.f_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_word", {32'd0, bus.f_dat_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.f_pc_o, e[95:32]);
        chk("sb_dat", {32'd0, bus.f_dat_o}, {32'd0, e[31:0]});
      end
    end
  endtask

  // One clock: check the current cycle, drive inputs, predict, advance.
  task automatic step(input logic ack, input logic [31:0] dat, input logic jmp,
                      input logic [63:0] xpc, input logic r);
    logic [63:0] jpc;
    check_outputs();
    rst         = r;
    bus.i_ack_i = ack;
    bus.i_dat_i = dat;
    bus.x_jmp_i = jmp;
    bus.x_pc_i  = xpc;
    jpc = xpc & ~64'd3;
    if (r) begin
      model_reset();
    end else begin
      m_fack = 1'b0;
      if (!m_active) begin
        m_active = 1'b1;
        if (jmp) m_adr = jpc;
      end else if (m_stale) begin
        if (ack) begin
          m_adr   = jmp ? jpc : m_next;
          m_stale = 1'b0;
        end else if (jmp) begin
          m_next = jpc;
        end
      end else if (ack && !jmp) begin
        m_fack = 1'b1;
        m_fdat = dat;
        m_fpc  = m_adr;
        exp_q.push_back({m_adr, dat});
        m_adr  = m_adr + 64'd4;
      end else if (ack) begin
        m_adr = jpc;
      end else if (jmp) begin
        m_stale = 1'b1;
        m_next  = jpc;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_ack_i = 1'b0;
    bus.i_dat_i = '0;
    bus.x_jmp_i = 1'b0;
    bus.x_pc_i  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Release reset: one idle cycle, then fetch at RESET_PC.
    step(0, 0, 0, 0, 0);
    chk("first_adr", bus.i_adr_o, 64'hFFFF_FFFF_FFFF_FF00);
    step(1, 32'h0040_0113, 0, 0, 0);
    step(1, 32'h0040_1113, 0, 0, 0);
    step(1, 32'h0040_2113, 0, 0, 0);
    chk("third_pc", bus.f_pc_o, 64'hFFFF_FFFF_FFFF_FF08);
    // Slow ack at ..FF0C.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 32'h0040_3113, 0, 0, 0);
    // Jump coinciding with an ack drops that word.
    step(1, 32'h0BAD_0BAD, 1, 64'h1000, 0);
    chk("jmp_adr", bus.i_adr_o, 64'h1000);
    step(1, 32'h1111_1111, 0, 0, 0);
    // Jump while waiting at 0x1004: old read must finish first.
    step(0, 0, 1, 64'h2003, 0);
    step(0, 0, 0, 0, 0);
    step(1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("discard_adr", bus.i_adr_o, 64'h2000);
    step(1, 32'h2222_2222, 0, 0, 0);
    // Two redirects during one wait: newest wins.
    step(0, 0, 1, 64'h5000, 0);
    step(0, 0, 1, 64'h3000, 0);
    step(1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("newest_wins", bus.i_adr_o, 64'h3000);
    // Address wrap at the top of the space.
    step(1, 32'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    step(1, 32'h3333_3333, 0, 0, 0);
    chk("wrap_adr", bus.i_adr_o, 64'h0);
    // Reset mid-wait, then a late ack while idle.
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 64'h4000, 1);
    step(1, 32'h4444_4444, 0, 0, 0);
    step(1, 32'h5555_5555, 0, 0, 0);
    chk("restart_pc", bus.f_pc_o, RPC);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] xpc;
      xpc = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                        : {32'd0, $urandom};
      step(($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 7) == 0), xpc,
           ($urandom_range(0, 63) == 0));
    end
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
